// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gray_pkg
//  Purpose  : Shared helpers for the Gray conversion arbiter: binary-to-Gray
//             conversion function and index-width helper.
//  Revision : 1.0  initial release
// ============================================================================
package gray_pkg;

    // Widest operand the conversion function handles; callers zero-extend.
    localparam int GRAY_MAXW = 64;

    // gray[MSB] = bin[MSB]; gray[i] = bin[i+1] ^ bin[i]. Zero-extension keeps
    // the operand's own MSB unchanged because the bit above it is 0.
    function automatic logic [GRAY_MAXW-1:0] bin2gray(input logic [GRAY_MAXW-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray_conv_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin priority search starting at a pointer, wrapping at
//             NREQ-1. Produces an enable-gated one-hot grant and the index.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    logic w_found;

    // First asserted request at or after ptr_i, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        idx_o   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = int'(ptr_i) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!w_found && req_i[j]) begin
                w_found = 1'b1;
                idx_o   = IDW'(j);
            end
        end
    end

    // Grant is withheld entirely when the consumer side cannot take a result.
    always_comb begin
        grant_o = '0;
        if (w_found && en_i) begin
            grant_o[idx_o] = 1'b1;
        end
    end

    assign any_o = w_found;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gray_conv_arbiter
//  Purpose  : One binary-to-Gray converter shared by NREQ requesters through a
//             round-robin arbiter, with a one-entry tagged output register.
//  Revision : 1.0  initial release
// ============================================================================
module gray_conv_arbiter
    import gray_pkg::*;
#(
    parameter int N    = 16,
    parameter int NREQ = 4,
    parameter int IDW  = clog2_min1(NREQ),
    parameter int CW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*N-1:0] req_binary,
    output logic [NREQ-1:0]   req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_gray,
    output logic [IDW-1:0]    out_id,
    output logic [CW-1:0]     conv_count
);

    // Output stage occupancy.
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]     state_q,  state_d;
    logic [N-1:0]   gray_q,   gray_d;
    logic [IDW-1:0] id_q,     id_d;
    logic [IDW-1:0] ptr_q,    ptr_d;
    logic [CW-1:0]  count_q,  count_d;

    logic           w_can_accept;
    logic           w_arb_en;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0] w_idx;
    logic           w_any;
    logic           w_xfer;
    logic [N-1:0]   w_bin;
    logic [N-1:0]   w_gray;
    logic [IDW-1:0] w_ptr_next;

    // A slot is available when empty or when the held result leaves this cycle.
    assign w_can_accept = (state_q == S_EMPTY) | out_ready;
    // No request is accepted while reset is asserted.
    assign w_arb_en     = w_can_accept & ~rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .en_i    (w_arb_en),
        .grant_o (w_grant),
        .idx_o   (w_idx),
        .any_o   (w_any)
    );

    assign w_xfer     = w_any & w_arb_en;
    assign w_bin      = req_binary[int'(w_idx)*N +: N];
    assign w_gray     = N'(bin2gray(GRAY_MAXW'(w_bin)));
    // Explicit wrap so non-power-of-two NREQ never reaches an unused index.
    assign w_ptr_next = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + IDW'(1);

    // Next-state: load on transfer, drain on consumer accept, otherwise hold.
    always_comb begin
        state_d = state_q;
        gray_d  = gray_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (w_xfer) begin
            state_d = S_FULL;
            gray_d  = w_gray;
            id_d    = w_idx;
            ptr_d   = w_ptr_next;
            count_d = count_q + CW'(1);
        end else if ((state_q == S_FULL) && out_ready) begin
            state_d = S_EMPTY;
        end
    end

    // State registers; reset discards any pending result without handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            gray_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            gray_q  <= gray_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    assign req_ready  = w_grant;
    assign out_valid  = (state_q == S_FULL);
    assign out_gray   = gray_q;
    assign out_id     = id_q;
    assign conv_count = count_q;

endmodule : gray_conv_arbiter
`default_nettype wire

// File: tb/tb_gray_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gray_conv_arbiter
//  Purpose  : Directed plus randomized checks of gray_conv_arbiter against a
//             behavioural reference model (N=4, NREQ=3, CW=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_gray_conv_arbiter;

    localparam int N    = 4;
    localparam int NREQ = 3;
    localparam int IDW  = 2;
    localparam int CW   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_binary;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_gray;
    logic [IDW-1:0]    out_id;
    logic [CW-1:0]     conv_count;

    gray_conv_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_binary (req_binary),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_gray   (out_gray),
        .out_id     (out_id),
        .conv_count (conv_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic       m_valid;
    logic [3:0] m_gray;
    int         m_id;
    int         m_ptr;
    int         m_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Gray code straight from the bit rule.
    function automatic logic [3:0] ref_gray(input logic [3:0] b);
        logic [3:0] g;
        for (int i = 0; i < 4; i++) begin
            g[i] = (i == 3) ? b[3] : (b[i+1] ^ b[i]);
        end
        return g;
    endfunction

    // Round-robin choice: first valid index scanning upward from m_ptr.
    function automatic int ref_pick(input logic [2:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drv(input logic r, input logic [2:0] v, input logic [3:0] b0,
                       input logic [3:0] b1, input logic [3:0] b2, input logic ordy);
        rst        = r;
        req_valid  = v;
        req_binary = {b2, b1, b0};
        out_ready  = ordy;
    endtask

    // One clock: check handshake before the edge, advance model, check outputs.
    task automatic tick(output int g);
        logic [2:0] exp_rdy;
        logic [3:0] bin;
        bit         can;
        #1;
        g       = -1;
        exp_rdy = '0;
        bin     = '0;
        if (!rst) begin
            can = !m_valid || out_ready;
            g   = ref_pick(req_valid, m_ptr);
            if (g >= 0 && can) begin
                exp_rdy[g] = 1'b1;
                bin = req_binary[g*4 +: 4];
            end else begin
                g = -1;
            end
        end
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 1'b0; m_gray = '0; m_id = 0; m_ptr = 0; m_count = 0;
        end else if (g >= 0) begin
            m_valid = 1'b1;
            m_gray  = ref_gray(bin);
            m_id    = g;
            m_ptr   = (g + 1) % NREQ;
            m_count = (m_count + 1) % (1 << CW);
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        chk("out_valid",  32'(out_valid),  32'(m_valid));
        chk("out_gray",   32'(out_gray),   32'(m_gray));
        chk("out_id",     32'(out_id),     32'(m_id));
        chk("conv_count", 32'(conv_count), 32'(m_count));
    endtask

    initial begin
        int         g;
        logic [3:0] exp_tab [3];
        logic [3:0] ops     [3];
        logic [2:0] pend;
        logic [3:0] held_gray;

        m_valid = 1'b0; m_gray = '0; m_id = 0; m_ptr = 0; m_count = 0;

        // Reset state
        drv(1'b1, 3'b000, 4'h0, 4'h0, 4'h0, 1'b1);
        tick(g); tick(g);
        chk("reset_valid", 32'(out_valid),  32'd0);
        chk("reset_gray",  32'(out_gray),   32'd0);
        chk("reset_count", 32'(conv_count), 32'd0);

        // Single request from requester 0
        drv(1'b0, 3'b001, 4'b1011, 4'h0, 4'h0, 1'b1);
        #1 chk("first_ready", 32'(req_ready), 32'b001);
        tick(g);
        chk("first_gray",  32'(out_gray),   32'b1110);
        chk("first_id",    32'(out_id),     32'd0);
        chk("first_count", 32'(conv_count), 32'd1);

        // All requesters continuously valid from a fresh pointer
        drv(1'b1, 3'b000, 4'h0, 4'h0, 4'h0, 1'b1);
        tick(g);
        exp_tab = '{4'b0100, 4'b1100, 4'b1000};
        drv(1'b0, 3'b111, 4'b0111, 4'b1000, 4'b1111, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick(g);
            chk("rr_id",    32'(out_id),    32'(k % 3));
            chk("rr_gray",  32'(out_gray),  32'(exp_tab[k % 3]));
            chk("rr_valid", 32'(out_valid), 32'd1);
        end

        // Backpressure with 1110 pending
        drv(1'b1, 3'b000, 4'h0, 4'h0, 4'h0, 1'b1);
        tick(g);
        drv(1'b0, 3'b001, 4'b1011, 4'h0, 4'h0, 1'b1);
        tick(g);
        drv(1'b0, 3'b010, 4'h0, 4'b0101, 4'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick(g);
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_gray",  32'(out_gray),  32'b1110);
            chk("bp_id",    32'(out_id),    32'd0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(req_ready), 32'b010);
        tick(g);
        chk("bp_release_gray", 32'(out_gray), 32'b0111);
        chk("bp_release_id",   32'(out_id),   32'd1);

        // Pointer follows the last grant
        drv(1'b1, 3'b000, 4'h0, 4'h0, 4'h0, 1'b1);
        tick(g);
        drv(1'b0, 3'b010, 4'h0, 4'h3, 4'h0, 1'b1);
        tick(g);
        drv(1'b0, 3'b101, 4'h6, 4'h0, 4'h9, 1'b1);
        #1 chk("ptr_ready_2", 32'(req_ready), 32'b100);
        tick(g);
        chk("ptr_id_2", 32'(out_id), 32'd2);
        drv(1'b0, 3'b001, 4'h6, 4'h0, 4'h0, 1'b1);
        tick(g);
        chk("ptr_id_0", 32'(out_id), 32'd0);

        // Reset while full mid-stream
        drv(1'b0, 3'b111, 4'h1, 4'h2, 4'h3, 1'b0);
        tick(g); tick(g);
        rst = 1'b1;
        tick(g);
        chk("midrst_valid", 32'(out_valid),  32'd0);
        chk("midrst_gray",  32'(out_gray),   32'd0);
        chk("midrst_count", 32'(conv_count), 32'd0);
        drv(1'b0, 3'b110, 4'h0, 4'h2, 4'h3, 1'b1);
        #1 chk("midrst_ready", 32'(req_ready), 32'b010);
        tick(g);

        // Counter wrap
        drv(1'b1, 3'b000, 4'h0, 4'h0, 4'h0, 1'b1);
        tick(g);
        drv(1'b0, 3'b001, 4'h5, 4'h0, 4'h0, 1'b1);
        for (int k = 0; k < 16; k++) tick(g);
        chk("wrap_16", 32'(conv_count), 32'd0);
        tick(g);
        chk("wrap_17", 32'(conv_count), 32'd1);

        // Randomized traffic with held requests and random backpressure/reset
        pend = '0;
        ops  = '{4'h0, 4'h0, 4'h0};
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!pend[r] && ($urandom_range(1, 0) == 1)) begin
                    pend[r] = 1'b1;
                    ops[r]  = 4'($urandom);
                end
            end
            held_gray = out_gray;
            drv(($urandom_range(49, 0) == 0), pend, ops[0], ops[1], ops[2],
                ($urandom_range(3, 0) != 0));
            tick(g);
            if (g >= 0) pend[g] = 1'b0;
        end
        if (held_gray !== 4'bx) begin end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_gray_conv_arbiter
`default_nettype wire
